// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a
// RUN/DRAIN/DONE controller that flushes the pipeline after a HALT.
module fetch_stage #(
  parameter int          N_BITS       = 32,
  parameter logic [5:0]  HALT_OPCODE  = 6'b111111,
  parameter int          DRAIN_CYCLES = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic [N_BITS-1:0] i_jump_direction,
  input  logic [N_BITS-1:0] i_instruction,
  output logic [N_BITS-1:0] o_pc,
  output logic [N_BITS-1:0] o_pc_plus4,
  output logic [N_BITS-1:0] o_instruction,
  output logic              o_valid,
  output logic              o_program_done,
  output logic [N_BITS-1:0] o_cycle_count
);

  localparam int CNT_W = $clog2(DRAIN_CYCLES) + 1;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  drain_cnt, drain_cnt_n;
  logic [N_BITS-1:0] pc_n, pc_plus4_n, instruction_n, cycle_count_n;
  logic              valid_n;

  logic [N_BITS-1:0] pc_inc;
  logic [N_BITS-1:0] redirect_pc;
  logic              is_halt;
  logic              unused_jump_bits;

  assign pc_inc           = o_pc + N_BITS'(4);
  assign redirect_pc      = {i_jump_direction[N_BITS-1:2], 2'b00};
  assign is_halt          = (i_instruction[31:26] == HALT_OPCODE);
  assign unused_jump_bits = ^i_jump_direction[1:0];

  // Only the state register drives this, so it never glitches on inputs.
  assign o_program_done = (state == DONE);

  always_comb begin
    state_n       = state;
    drain_cnt_n   = drain_cnt;
    pc_n          = o_pc;
    pc_plus4_n    = o_pc_plus4;
    instruction_n = o_instruction;
    valid_n       = o_valid;
    cycle_count_n = o_cycle_count;

    if (i_enable) begin
      if ((state != DONE) && (o_cycle_count != '1))
        cycle_count_n = o_cycle_count + N_BITS'(1);

      case (state)
        RUN: begin
          if (i_flush) begin
            pc_n          = redirect_pc;
            pc_plus4_n    = '0;
            instruction_n = '0;
            valid_n       = 1'b0;
          end else if (!i_stall) begin
            instruction_n = i_instruction;
            pc_plus4_n    = pc_inc;
            valid_n       = 1'b1;
            if (is_halt) begin
              drain_cnt_n = '0;
              state_n     = DRAIN;
            end else begin
              pc_n = pc_inc;
            end
          end
        end
        // A flush while draining means the HALT sat on a mispredicted path.
        DRAIN: begin
          if (i_flush) begin
            pc_n          = redirect_pc;
            pc_plus4_n    = '0;
            instruction_n = '0;
            valid_n       = 1'b0;
            state_n       = RUN;
          end else begin
            pc_plus4_n    = '0;
            instruction_n = '0;
            valid_n       = 1'b0;
            drain_cnt_n   = drain_cnt + CNT_W'(1);
            if (drain_cnt == CNT_W'(DRAIN_CYCLES - 1))
              state_n = DONE;
          end
        end
        DONE: begin
          pc_plus4_n    = '0;
          instruction_n = '0;
          valid_n       = 1'b0;
        end
        default: state_n = RUN;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state         <= RUN;
      drain_cnt     <= '0;
      o_pc          <= '0;
      o_pc_plus4    <= '0;
      o_instruction <= '0;
      o_valid       <= 1'b0;
      o_cycle_count <= '0;
    end else begin
      state         <= state_n;
      drain_cnt     <= drain_cnt_n;
      o_pc          <= pc_n;
      o_pc_plus4    <= pc_plus4_n;
      o_instruction <= instruction_n;
      o_valid       <= valid_n;
      o_cycle_count <= cycle_count_n;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage: a vector table for the basic
// fetch/stall/flush/wrap behaviour plus hand sequences for freeze, HALT drain and reset.
module tb_fetch_stage;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_enable;
  logic        i_stall;
  logic        i_flush;
  logic [31:0] i_jump_direction;
  logic [31:0] i_instruction;
  logic [31:0] o_pc;
  logic [31:0] o_pc_plus4;
  logic [31:0] o_instruction;
  logic        o_valid;
  logic        o_program_done;
  logic [31:0] o_cycle_count;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] HALT = 32'hFC00_0000;

  fetch_stage #(
    .N_BITS      (32),
    .HALT_OPCODE (6'b111111),
    .DRAIN_CYCLES(4)
  ) dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_enable        (i_enable),
    .i_stall         (i_stall),
    .i_flush         (i_flush),
    .i_jump_direction(i_jump_direction),
    .i_instruction   (i_instruction),
    .o_pc            (o_pc),
    .o_pc_plus4      (o_pc_plus4),
    .o_instruction   (o_instruction),
    .o_valid         (o_valid),
    .o_program_done  (o_program_done),
    .o_cycle_count   (o_cycle_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    string       name;
    logic        rst_n;
    logic        en;
    logic        stall;
    logic        flush;
    logic [31:0] jump;
    logic [31:0] instr;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc4;
    logic        exp_valid;
    logic        exp_done;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  // Drive one set of inputs, clock once, and settle just after the edge.
  task automatic applyStimulus(input logic rst_n, input logic en, input logic stall,
                               input logic flush, input logic [31:0] jump,
                               input logic [31:0] instr);
    i_reset          = rst_n;
    i_enable         = en;
    i_stall          = stall;
    i_flush          = flush;
    i_jump_direction = jump;
    i_instruction    = instr;
    @(posedge i_clk);
    #1;
  endtask

  task automatic cmp(input string name, input string field,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s.%s actual=%h expected=%h", name, field, act, exp);
    end
  endtask

  // The drain phase leaves o_pc_plus4 unspecified, so chk_pc4 lets those steps skip it.
  task automatic checkOutput(input string name, input logic [31:0] pc,
                             input logic [31:0] instr, input logic [31:0] pc4,
                             input logic chk_pc4, input logic valid,
                             input logic done, input logic [31:0] cnt);
    cmp(name, "pc", o_pc, pc);
    cmp(name, "instr", o_instruction, instr);
    if (chk_pc4) cmp(name, "pc4", o_pc_plus4, pc4);
    cmp(name, "valid", {31'b0, o_valid}, {31'b0, valid});
    cmp(name, "done", {31'b0, o_program_done}, {31'b0, done});
    cmp(name, "cnt", o_cycle_count, cnt);
  endtask

  initial begin
    // name, rst_n, en, stall, flush, jump, instr -> pc, instr, pc4, valid, done, cnt
    vecs.push_back('{"reset",       0, 1, 0, 0, 32'h0,         32'h11, 32'h0,         32'h0,  32'h0,  0, 0, 0});
    vecs.push_back('{"fetch0",      1, 1, 0, 0, 32'h0,         32'h11, 32'h4,         32'h11, 32'h4,  1, 0, 1});
    vecs.push_back('{"fetch1",      1, 1, 0, 0, 32'h0,         32'h22, 32'h8,         32'h22, 32'h8,  1, 0, 2});
    vecs.push_back('{"fetch2",      1, 1, 0, 0, 32'h0,         32'h33, 32'hC,         32'h33, 32'hC,  1, 0, 3});
    vecs.push_back('{"stall_flush", 1, 1, 1, 1, 32'h43,        32'h44, 32'h40,        32'h0,  32'h0,  0, 0, 4});
    vecs.push_back('{"stall_bub",   1, 1, 1, 0, 32'h0,         32'h55, 32'h40,        32'h0,  32'h0,  0, 0, 5});
    vecs.push_back('{"fetch40",     1, 1, 0, 0, 32'h0,         32'h66, 32'h44,        32'h66, 32'h44, 1, 0, 6});
    vecs.push_back('{"stall_hold",  1, 1, 1, 0, 32'h0,         32'h77, 32'h44,        32'h66, 32'h44, 1, 0, 7});
    vecs.push_back('{"redir_top",   1, 1, 0, 1, 32'hFFFFFFFE,  32'h88, 32'hFFFFFFFC,  32'h0,  32'h0,  0, 0, 8});
    vecs.push_back('{"pc_wrap",     1, 1, 0, 0, 32'h0,         32'h12, 32'h0,         32'h12, 32'h0,  1, 0, 9});
    vecs.push_back('{"fetch_w1",    1, 1, 0, 0, 32'h0,         32'h01, 32'h4,         32'h01, 32'h4,  1, 0, 10});
    vecs.push_back('{"fetch_w2",    1, 1, 0, 0, 32'h0,         32'h02, 32'h8,         32'h02, 32'h8,  1, 0, 11});

    applyStimulus(0, 0, 0, 0, 32'h0, 32'h0);
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst_n, vecs[i].en, vecs[i].stall, vecs[i].flush,
                    vecs[i].jump, vecs[i].instr);
      checkOutput(vecs[i].name, vecs[i].exp_pc, vecs[i].exp_instr, vecs[i].exp_pc4, 1'b1,
                  vecs[i].exp_valid, vecs[i].exp_done, vecs[i].exp_cnt);
    end

    // Disabled cycles must ignore even a flush carrying a HALT-looking word.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, 0, k[0], 1, 32'h200, HALT);
      checkOutput("freeze", 32'h8, 32'h02, 32'h8, 1'b1, 1'b1, 1'b0, 32'd11);
    end

    // HALT fetched at 0x08, then four NOP drain edges; stall is ignored while draining.
    applyStimulus(1, 1, 0, 0, 32'h0, HALT);
    checkOutput("halt_latch", 32'h8, HALT, 32'hC, 1'b1, 1'b1, 1'b0, 32'd12);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 1, k[0], 0, 32'h0, 32'h99);
      checkOutput("drain", 32'h8, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'd13 + k);
    end
    applyStimulus(1, 1, 0, 0, 32'h0, 32'h99);
    checkOutput("drain_last", 32'h8, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'd16);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 1, 1, 1, 32'h300, 32'h1234);
      checkOutput("done_hold", 32'h8, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'd16);
    end

    // Reset out of DONE overrides a deasserted enable; fetch restarts at 0.
    applyStimulus(0, 0, 0, 0, 32'h0, 32'hAA);
    checkOutput("rst_done", 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'd0);
    applyStimulus(1, 1, 0, 0, 32'h0, 32'hAA);
    checkOutput("restart", 32'h4, 32'hAA, 32'h4, 1'b1, 1'b1, 1'b0, 32'd1);

    // A flush in the second drain cycle cancels the HALT and resumes RUN.
    applyStimulus(1, 1, 0, 0, 32'h0, 32'hBB);
    checkOutput("pre_halt", 32'h8, 32'hBB, 32'h8, 1'b1, 1'b1, 1'b0, 32'd2);
    applyStimulus(1, 1, 0, 0, 32'h0, HALT);
    checkOutput("halt2", 32'h8, HALT, 32'hC, 1'b1, 1'b1, 1'b0, 32'd3);
    applyStimulus(1, 1, 0, 0, 32'h0, 32'h0);
    checkOutput("drain2_1", 32'h8, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'd4);
    applyStimulus(1, 1, 0, 1, 32'h100, 32'h0);
    checkOutput("drain_flush", 32'h100, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'd5);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, 1, 0, 0, 32'h0, 32'hC0 + k);
      checkOutput("post_cancel", 32'h104 + 4 * k, 32'hC0 + k, 32'h104 + 4 * k, 1'b1,
                  1'b1, 1'b0, 32'd6 + k);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The module SHALL have parameter N_BITS, default 32, meaning the width of the PC, instruction and data paths.
REQ-002 The module SHALL have parameter HALT_OPCODE, default 6'b111111, meaning the instruction[31:26] value that marks end of program.
REQ-003 The module SHALL have parameter DRAIN_CYCLES, default 4, meaning the number of NOP cycles inserted after a HALT before done.
REQ-004 i_clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 i_reset  in  1  reset, synchronous, active-low (0 = reset).
REQ-006 i_enable  in  1  debug-unit run/step enable; 0 freezes all state.
REQ-007 i_stall  in  1  load-use stall from the hazard detector; holds the PC and the IF/ID register.
REQ-008 i_flush  in  1  control-hazard redirect from the hazard detector.
REQ-009 i_jump_direction  in  N_BITS  redirect target, valid when i_flush=1.
REQ-010 i_instruction  in  N_BITS  combinational instruction-memory read data at o_pc.
REQ-011 o_pc  out  N_BITS  current fetch address to instruction memory.
REQ-012 o_pc_plus4  out  N_BITS  IF/ID-registered PC+4 of the held instruction.
REQ-013 o_instruction  out  N_BITS  IF/ID-registered instruction.
REQ-014 o_valid  out  1  IF/ID contents are a real instruction (0 = bubble/NOP).
REQ-015 o_program_done  out  1  HALT has fully drained.
REQ-016 o_cycle_count  out  N_BITS  count of enabled cycles in RUN or DRAIN.

Function
REQ-017 The module SHALL implement states RUN, DRAIN and DONE.
REQ-018 The module SHALL hold every register unchanged in any cycle with i_enable=0, including state, drain counter and o_cycle_count.
REQ-019 In RUN with i_flush=1, the module SHALL load o_pc <= {i_jump_direction[N_BITS-1:2],2'b00} and clear o_instruction to 0, o_valid to 0 and o_pc_plus4 to 0, regardless of i_stall (flush beats stall).
REQ-020 In RUN with i_flush=0 and i_stall=1, the module SHALL hold o_pc, o_instruction, o_pc_plus4 and o_valid.
REQ-021 In RUN with no flush and no stall, the module SHALL load o_pc <= o_pc+4 (modulo 2^N_BITS, with 0xFFFFFFFC wrapping to 0) and load IF/ID with {i_instruction, o_pc+4, valid=1}, all on the same edge.
REQ-022 In RUN with no flush, no stall and i_instruction[31:26]==HALT_OPCODE, the module SHALL latch the HALT into IF/ID (valid=1), hold o_pc, clear the drain counter and go to DRAIN.
REQ-023 In DRAIN without flush, each enabled cycle SHALL load IF/ID with a NOP (instruction 0, valid 0), hold o_pc and increment the drain counter, ignoring i_stall.
REQ-024 In DRAIN, when the drain counter reaches DRAIN_CYCLES-1, the module SHALL go to DONE on that edge.
REQ-025 In DRAIN with i_flush=1, the module SHALL cancel the HALT as speculative: perform the REQ-019 redirect and return to RUN.
REQ-026 In DONE, the module SHALL hold o_pc, keep IF/ID at NOP with valid 0, keep o_program_done=1 and ignore i_flush, i_stall and i_instruction until reset.
REQ-027 o_program_done SHALL be 1 exactly when the state is DONE (registered, no combinational path from inputs).
REQ-028 o_cycle_count SHALL increment by 1 on each enabled edge taken in RUN or DRAIN, saturating at all-ones.
REQ-029 o_cycle_count SHALL not increment in DONE.
REQ-030 o_pc SHALL be the only address source to instruction memory, and instruction memory latency SHALL be zero cycles.

Reset
REQ-031 When i_reset=0 at a rising edge, the module SHALL set o_pc=0, o_pc_plus4=0, o_instruction=0, o_valid=0, o_cycle_count=0, drain counter=0, state=RUN and o_program_done=0, overriding i_enable.
REQ-032 Reset asserted in any state, including mid-DRAIN or DONE, SHALL take effect on the next edge; fetch SHALL resume from address 0 on the first edge with i_reset=1.

Verification
REQ-033 The bench SHALL cover sequential fetch: reset, then 3 enabled cycles with instruction words 0x11,0x22,0x33 -> o_pc=0x0C, o_instruction=0x33, o_pc_plus4=0x0C, o_valid=1, o_cycle_count=3.
REQ-034 The bench SHALL cover simultaneous stall and flush: i_stall=1 and i_flush=1 with i_jump_direction=0x43 -> o_pc=0x40, o_valid=0; then i_stall=1 alone -> o_pc stays 0x40.
REQ-035 The bench SHALL cover HALT drain: HALT word 0xFC000000 fetched at 0x08 -> o_valid=1 with the HALT in IF/ID, then 4 NOP cycles, then o_program_done=1 with o_pc held at 0x08 and o_cycle_count frozen.
REQ-036 The bench SHALL cover flush during DRAIN: i_flush=1 with i_jump_direction=0x100 in the 2nd DRAIN cycle -> state RUN, o_pc=0x100, and o_program_done never asserts.
REQ-037 The bench SHALL cover enable freeze and PC wrap: i_enable=0 for 5 cycles -> all outputs unchanged; separately, redirect to 0xFFFFFFFC then advance -> o_pc=0x00000000.
REQ-038 The bench SHALL cover reset in DONE: i_reset=0 for 1 cycle -> o_program_done=0, o_pc=0, o_cycle_count=0, then fetch restarts from address 0.
